uart_char_rx: RTL and testbench

UART_CHAR_RX -- requirements
Module: uart_char_rx

---
 rtl/uart_char_rx.sv | 192 +++++++++++++++++++
 tb/tb_uart_char_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_char_rx.sv
// uart_char_rx -- 8N1 UART character receiver (idle-high line, LSB first).
//
// The line is oversampled with CLKS_PER_BIT system clocks per bit. A falling
// edge seen in IDLE starts a frame. The start bit is re-checked at mid-bit.
// Each data bit and the stop bit are then sampled one full bit period later.
// Good characters are presented on data with a one-cycle valid strobe. A low
// stop bit gives a one-cycle frame_err strobe and leaves data untouched.
//
// Optional feature macro: UART_CHAR_RX_SYNC_EN
//   defined   -> rx passes through a two-flop synchroniser (reset value 1)
//                before the FSM. Every detection and strobe moves two cycles
//                later.
//   undefined -> the FSM samples rx directly.
module uart_char_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Last counter value of the half bit that ends at the centre of the start bit.
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  // Last counter value of a full bit period, measured centre to centre.
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  IDX_LAST  = 3'd7;

  // Line value as seen by the FSM.
  logic rx_s;

`ifdef UART_CHAR_RX_SYNC_EN
  logic sync1_r;
  logic sync2_r;

  // Two-flop synchroniser. It resets to the idle (high) level so that reset
  // release never looks like a start edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
    end
  end

  assign rx_s = sync2_r;
`else
  assign rx_s = rx;
`endif

  state_t      state_r;
  state_t      state_nx;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nx;
  logic [2:0]  idx_r;
  logic [2:0]  idx_nx;
  logic [7:0]  shift_r;
  logic [7:0]  shift_nx;
  logic [7:0]  data_r;
  logic [7:0]  data_nx;
  logic        valid_r;
  logic        valid_nx;
  logic        ferr_r;
  logic        ferr_nx;
  logic        busy_r;
  logic        busy_nx;

  // State and datapath registers. A reset discards any partial character.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      idx_r   <= idx_nx;
      shift_r <= shift_nx;
      data_r  <= data_nx;
      valid_r <= valid_nx;
      ferr_r  <= ferr_nx;
      busy_r  <= busy_nx;
    end
  end

  // Next-state logic: bit timing, sampling, character assembly and strobes.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    idx_nx   = idx_r;
    shift_nx = shift_r;
    data_nx  = data_r;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;

    case (state_r)
      IDLE: begin
        cnt_nx = 16'd0;
        idx_nx = 3'd0;
        if (!rx_s) begin
          state_nx = START;
        end else begin
          state_nx = IDLE;
        end
      end

      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nx = 16'd0;
          idx_nx = 3'd0;
          if (!rx_s) begin
            // The start bit is still low at its centre, so this is a real frame.
            state_nx = DATA;
          end else begin
            // The low pulse was too short to be a start bit. Drop it silently.
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt_r + 16'd1;
        end
      end

      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nx           = 16'd0;
          shift_nx[idx_r]  = rx_s;
          if (idx_r == IDX_LAST) begin
            idx_nx   = 3'd0;
            state_nx = STOP;
          end else begin
            idx_nx = idx_r + 3'd1;
          end
        end else begin
          cnt_nx = cnt_r + 16'd1;
        end
      end

      STOP: begin
        if (cnt_r == BIT_LAST) begin
          // Go straight back to IDLE so the next start bit, which may begin
          // right after this stop-bit centre, is caught on the next cycle.
          cnt_nx   = 16'd0;
          state_nx = IDLE;
          if (rx_s) begin
            data_nx  = shift_r;
            valid_nx = 1'b1;
          end else begin
            ferr_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt_r + 16'd1;
        end
      end

      default: begin
        state_nx = IDLE;
        cnt_nx   = 16'd0;
        idx_nx   = 3'd0;
      end
    endcase

    // busy is registered. It follows the state that is entered on this edge.
    if (state_nx != IDLE) begin
      busy_nx = 1'b1;
    end else begin
      busy_nx = 1'b0;
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = ferr_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_char_rx.sv
// tb_uart_char_rx -- self-checking bench for uart_char_rx.
// The driver records each frame it sends as an event: the edge where the start
// bit is first seen, the edge where the character completes, and its outcome.
// A compare process recomputes valid / frame_err / data / busy from that event
// list on every cycle. Directed literal checks pin the timing and data values.
// Honours UART_CHAR_RX_SYNC_EN so that it matches the build of the design.
module tb_uart_char_rx;

  localparam int C = 16;
`ifdef UART_CHAR_RX_SYNC_EN
  localparam int LAT     = 2;
  localparam int LAT_LIT = 154;
`else
  localparam int LAT     = 0;
  localparam int LAT_LIT = 152;
`endif

  localparam int K_OK   = 0;
  localparam int K_FERR = 1;
  localparam int K_GL   = 2;

  typedef struct {
    int         start;
    int         finish;
    int         kind;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_char_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .clr       (clr),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t        ev_q[$];
  int         vcyc[$];
  logic [7:0] vdat[$];
  int         ferr_cnt = 0;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         n_print  = 0;
  bit         mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_print < 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      n_print++;
    end
  endtask

  // Per-cycle compare against the expectations derived from the event list.
  always @(negedge clk) begin
    logic       e_valid;
    logic       e_ferr;
    logic       e_busy;
    logic [7:0] e_data;
    int         best;
    if (mon_en) begin
      e_valid = 1'b0;
      e_ferr  = 1'b0;
      e_busy  = 1'b0;
      e_data  = 8'h00;
      best    = -1;
      if (clr) begin
        foreach (ev_q[i]) begin
          if (ev_q[i].start <= cyc && cyc < ev_q[i].finish) e_busy = 1'b1;
          if (ev_q[i].finish == cyc && ev_q[i].kind == K_OK)   e_valid = 1'b1;
          if (ev_q[i].finish == cyc && ev_q[i].kind == K_FERR) e_ferr  = 1'b1;
          if (ev_q[i].kind == K_OK && ev_q[i].finish <= cyc && ev_q[i].finish > best) begin
            best   = ev_q[i].finish;
            e_data = ev_q[i].d;
          end
        end
      end
      check("valid", {31'd0, valid}, {31'd0, e_valid});
      check("frame_err", {31'd0, frame_err}, {31'd0, e_ferr});
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("data", {24'd0, data}, {24'd0, e_data});
      if (valid === 1'b1) begin
        vcyc.push_back(cyc);
        vdat.push_back(data);
      end
      if (frame_err === 1'b1) ferr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One data bit. With noise, the line flips for one cycle well before the
  // bit centre.
  task automatic hold_bit(input logic b, input bit noise);
    rx = b;
    if (noise) begin
      tick(2);
      rx = ~b;
      tick(1);
      rx = b;
      tick(C - 3);
    end else begin
      tick(C);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] d, input int len);
    ev_t e;
    e.start  = cyc + 1 + LAT;
    e.finish = e.start + len;
    e.kind   = kind;
    e.d      = d;
    ev_q.push_back(e);
  endtask

  // Full frame. A bad stop bit is held low only past its centre, so the line
  // is idle before the next start edge can be accepted.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit noise);
    push_ev(stop ? K_OK : K_FERR, d, C / 2 + 9 * C);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) hold_bit(d[i], noise);
    if (stop) begin
      rx = 1'b1;
      tick(C);
    end else begin
      rx = 1'b0;
      tick(C / 2 + 1);
      rx = 1'b1;
      tick(C / 2 - 1);
    end
  endtask

  // Low pulse shorter than half a bit, followed by enough idle time to return.
  task automatic glitch(input int len_low);
    push_ev(K_GL, 8'h00, C / 2);
    rx = 1'b0;
    tick(len_low);
    rx = 1'b1;
    tick(C / 2 + 1);
  endtask

  task automatic do_reset();
    ev_q.delete();
    clr = 1'b0;
    rx  = 1'b1;
    #1;
    check("rst_data", {24'd0, data}, 32'h0000_0000);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    tick(3);
    clr = 1'b1;
    tick(4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int base;
    int ferr0;
    int choice;
    clr = 1'b1;
    rx  = 1'b1;
    #2;
    mon_en = 1'b1;
    do_reset();

    // Single good character '9'.
    t0 = cyc + 1;
    send_frame(8'h39, 1'b1, 1'b0);
    tick(4);
    check("c9_count", vcyc.size(), 32'd1);
    if (vcyc.size() == 1) begin
      check("c9_latency", vcyc[0] - t0, LAT_LIT);
      check("c9_data", {24'd0, vdat[0]}, 32'h39);
    end
    check("c9_no_ferr", ferr_cnt, 32'd0);

    // 'A' with a low stop bit: framing error, data keeps '9'.
    send_frame(8'h41, 1'b0, 1'b0);
    tick(4);
    check("bad_stop_ferr", ferr_cnt, 32'd1);
    check("bad_stop_novalid", vcyc.size(), 32'd1);
    check("bad_stop_data", {24'd0, data}, 32'h39);

    // Four-cycle low pulse: no frame at all.
    glitch(4);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_novalid", vcyc.size(), 32'd1);
    check("glitch_noferr", ferr_cnt, 32'd1);

    // '1', '+', '2' back to back.
    base = vcyc.size();
    send_frame(8'h31, 1'b1, 1'b0);
    send_frame(8'h2B, 1'b1, 1'b0);
    send_frame(8'h32, 1'b1, 1'b0);
    tick(4);
    check("b2b_count", vcyc.size() - base, 32'd3);
    if (vcyc.size() == base + 3) begin
      check("b2b_d0", {24'd0, vdat[base]}, 32'h31);
      check("b2b_d1", {24'd0, vdat[base+1]}, 32'h2B);
      check("b2b_d2", {24'd0, vdat[base+2]}, 32'h32);
      check("b2b_gap0", vcyc[base+1] - vcyc[base], 32'd160);
      check("b2b_gap1", vcyc[base+2] - vcyc[base+1], 32'd160);
    end

    // Reset part-way through the data bits of 0x55, then a fresh frame 0x2A.
    push_ev(K_OK, 8'h55, C / 2 + 9 * C);
    rx = 1'b0;
    tick(C);
    for (int i = 0; i < 3; i++) hold_bit(1'(i % 2 == 0), 1'b0);
    tick(5);
    base = vcyc.size();
    do_reset();
    t0 = cyc + 1;
    send_frame(8'h2A, 1'b1, 1'b0);
    tick(4);
    check("post_rst_count", vcyc.size() - base, 32'd1);
    check("post_rst_data", {24'd0, data}, 32'h2A);
    if (vcyc.size() == base + 1)
      check("post_rst_latency", vcyc[base] - t0, LAT_LIT);

    // Randomised traffic: good/bad frames, glitches, mid-bit noise, gaps.
    ferr0 = ferr_cnt;
    for (int k = 0; k < 30; k++) begin
      choice = $urandom_range(0, 9);
      if (choice == 0) begin
        glitch($urandom_range(1, C / 2));
      end else if (choice == 1) begin
        send_frame(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
      end else begin
        send_frame(8'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 2) != 0) begin
        rx = 1'b1;
        tick($urandom_range(1, 20));
      end
    end
    tick(20);
    check("rand_ferr_nonneg", 32'(ferr_cnt >= ferr0), 32'd1);
    mon_en = 1'b0;

    if (n_fail == 0)
      $display("PASS: %0d failed, %0d/%0d checks passed", n_fail, n_pass, n_checks);
    else
      $display("FAIL: %0d failed, %0d/%0d checks passed", n_fail, n_pass, n_checks);
    $finish;
  end

endmodule
